// File: rtl/mpi_pkg.sv
// Shared MPI bus definitions: data/address widths, responder FSM states, default base address.
package mpi_pkg;

   localparam int unsigned MPI_AW      = 16;
   localparam int unsigned MPI_DW      = 16;
   localparam int unsigned MPI_BW      = 8;
   localparam int unsigned MPI_IDX_W   = 2;
   localparam int unsigned MPI_REG_NUM = 4;
   localparam int unsigned MPI_CNT_W   = 3;

   localparam logic [MPI_AW-1:0] MPI_BASE_ADDR_DEF = 16'o177560;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SKIP    = 3'd1,
      ST_SEL     = 3'd2,
      ST_RD      = 3'd3,
      ST_RD_RPLY = 3'd4,
      ST_WR      = 3'd5,
      ST_WR_RPLY = 3'd6
   } mpi_state_e;

endpackage

// File: rtl/mpi_sync.sv
// N-stage synchroniser for one asynchronous, true-active bus strobe.
module mpi_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= '0;
      else        ff_q <= {ff_q[STAGES-2:0], d_i};
   end

   assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/mpi_slave_resp.sv
// MPI bus responder: 4-word register bank in the I/O page answering DATI, DATO(B) and DATIO with RPLY.
module mpi_slave_resp
   import mpi_pkg::*;
#(
   parameter logic [MPI_AW-1:0] BASE_ADDR   = MPI_BASE_ADDR_DEF,
   parameter int unsigned       REG_NUM     = MPI_REG_NUM,
   parameter int unsigned       RPLY_DLY    = 1,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MPI_DW-1:0]    ad_in,
   output logic [MPI_DW-1:0]    ad_out,
   output logic                 ad_oe,
   input  logic                 sync_n,
   input  logic                 din_n,
   input  logic                 dout_n,
   input  logic                 wtbt_n,
   input  logic                 bs_n,
   input  logic                 init_n,
   output logic                 rply_oe,
   output logic [63:0]          reg_q,
   output logic                 wr_stb,
   output logic [MPI_IDX_W-1:0] wr_idx
);

   logic s_sync, s_din, s_dout, s_init;

   mpi_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (.clk(clk), .rst_n(rst_n), .d_i(~sync_n), .q_o(s_sync));
   mpi_sync #(.STAGES(SYNC_STAGES)) u_sync_din  (.clk(clk), .rst_n(rst_n), .d_i(~din_n),  .q_o(s_din));
   mpi_sync #(.STAGES(SYNC_STAGES)) u_sync_dout (.clk(clk), .rst_n(rst_n), .d_i(~dout_n), .q_o(s_dout));
   mpi_sync #(.STAGES(SYNC_STAGES)) u_sync_init (.clk(clk), .rst_n(rst_n), .d_i(~init_n), .q_o(s_init));

   mpi_state_e                           state_q, state_d;
   logic [MPI_CNT_W-1:0]                 cnt_q, cnt_d;
   logic [MPI_IDX_W-1:0]                 idx_q, idx_d;
   logic                                 odd_q, odd_d;
   logic                                 sync_prev_q;
   logic [REG_NUM-1:0][MPI_DW-1:0]       regs_q, regs_d;
   logic [MPI_DW-1:0]                    ad_out_q, ad_out_d;
   logic                                 ad_oe_q, ad_oe_d;
   logic                                 rply_oe_q, rply_oe_d;
   logic                                 wr_stb_q, wr_stb_d;
   logic [MPI_IDX_W-1:0]                 wr_idx_q, wr_idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         odd_q       <= 1'b0;
         sync_prev_q <= 1'b0;
         regs_q      <= '0;
         ad_out_q    <= '0;
         ad_oe_q     <= 1'b0;
         rply_oe_q   <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_idx_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         odd_q       <= odd_d;
         sync_prev_q <= s_sync;
         regs_q      <= regs_d;
         ad_out_q    <= ad_out_d;
         ad_oe_q     <= ad_oe_d;
         rply_oe_q   <= rply_oe_d;
         wr_stb_q    <= wr_stb_d;
         wr_idx_q    <= wr_idx_d;
      end
   end

   // Next-state and registered-output logic; bus INIT overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      odd_d     = odd_q;
      regs_d    = regs_q;
      ad_out_d  = ad_out_q;
      ad_oe_d   = ad_oe_q;
      rply_oe_d = rply_oe_q;
      wr_stb_d  = 1'b0;
      wr_idx_d  = wr_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (s_sync && !sync_prev_q) begin
               idx_d = ad_in[2:1];
               odd_d = ad_in[0];
               if (!bs_n && (ad_in[MPI_AW-1:3] == BASE_ADDR[MPI_AW-1:3])) state_d = ST_SEL;
               else                                                        state_d = ST_SKIP;
            end
         end
         ST_SKIP: begin
            if (!s_sync) state_d = ST_IDLE;
         end
         ST_SEL: begin
            if (!s_sync) begin
               state_d = ST_IDLE;
            end else if (s_din) begin
               ad_out_d = regs_q[idx_q];
               if (RPLY_DLY == 0) begin
                  state_d   = ST_RD_RPLY;
                  ad_oe_d   = 1'b1;
                  rply_oe_d = 1'b1;
               end else begin
                  state_d = ST_RD;
                  cnt_d   = MPI_CNT_W'(RPLY_DLY - 1);
               end
            end else if (s_dout) begin
               // WTBT low in the data phase selects a byte lane by the address LSB.
               if (!wtbt_n) begin
                  if (odd_q) regs_d[idx_q][MPI_DW-1:MPI_BW] = ad_in[MPI_DW-1:MPI_BW];
                  else       regs_d[idx_q][MPI_BW-1:0]      = ad_in[MPI_BW-1:0];
               end else begin
                  regs_d[idx_q] = ad_in;
               end
               wr_stb_d = 1'b1;
               wr_idx_d = idx_q;
               if (RPLY_DLY == 0) begin
                  state_d   = ST_WR_RPLY;
                  rply_oe_d = 1'b1;
               end else begin
                  state_d = ST_WR;
                  cnt_d   = MPI_CNT_W'(RPLY_DLY - 1);
               end
            end
         end
         ST_RD: begin
            if (!s_sync) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d   = ST_RD_RPLY;
               ad_oe_d   = 1'b1;
               rply_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WR: begin
            if (!s_sync) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d   = ST_WR_RPLY;
               rply_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RD_RPLY: begin
            if (!s_sync || !s_din) begin
               state_d   = s_sync ? ST_SEL : ST_IDLE;
               ad_oe_d   = 1'b0;
               rply_oe_d = 1'b0;
            end
         end
         ST_WR_RPLY: begin
            if (!s_sync || !s_dout) begin
               state_d   = s_sync ? ST_SEL : ST_IDLE;
               rply_oe_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (s_init) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         idx_d     = '0;
         odd_d     = 1'b0;
         regs_d    = '0;
         ad_out_d  = '0;
         ad_oe_d   = 1'b0;
         rply_oe_d = 1'b0;
         wr_stb_d  = 1'b0;
         wr_idx_d  = '0;
      end
   end

   assign ad_out  = ad_out_q;
   assign ad_oe   = ad_oe_q;
   assign rply_oe = rply_oe_q;
   assign reg_q   = regs_q;
   assign wr_stb  = wr_stb_q;
   assign wr_idx  = wr_idx_q;

endmodule

// File: tb/tb_mpi_slave_resp.sv
// Bench for mpi_slave_resp: directed bus cycles plus random DATI/DATO/DATOB/DATIO against a register-array model.
module tb_mpi_slave_resp;

   localparam logic [15:0] BASE = 16'o177560;

   logic        clk, rst_n;
   logic [15:0] ad_in, ad_out;
   logic        ad_oe, sync_n, din_n, dout_n, wtbt_n, bs_n, init_n, rply_oe, wr_stb;
   logic [63:0] reg_q;
   logic [1:0]  wr_idx;

   logic [15:0] mdl [4];
   int          n_chk, n_err;

   mpi_slave_resp dut (
      .clk(clk), .rst_n(rst_n), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
      .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .bs_n(bs_n),
      .init_n(init_n), .rply_oe(rply_oe), .reg_q(reg_q), .wr_stb(wr_stb), .wr_idx(wr_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mdl_bank();
      return {mdl[3], mdl[2], mdl[1], mdl[0]};
   endfunction

   task automatic addr_phase(input logic [15:0] a, input logic bs, input logic wi);
      ad_in  = a;
      bs_n   = ~bs;
      wtbt_n = ~wi;
      @(negedge clk);
      sync_n = 1'b0;
      repeat (4) @(negedge clk);
      ad_in  = 16'($urandom);
      wtbt_n = 1'b1;
   endtask

   task automatic end_cycle();
      sync_n = 1'b1;
      din_n  = 1'b1;
      dout_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic rd_data(input logic [15:0] exp);
      int lat;
      lat   = 99;
      din_n = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (rply_oe) begin lat = k; break; end
      end
      check("rd_latency", 64'(lat), 64'd4);
      check("rd_ad_oe", 64'(ad_oe), 64'd1);
      check("rd_data", 64'(ad_out), 64'(exp));
      @(negedge clk);
      din_n = 1'b1;
      lat   = 99;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (!rply_oe) begin lat = k; break; end
      end
      check("rd_release_lat", 64'(lat), 64'd3);
      check("rd_release_oe", 64'(ad_oe), 64'd0);
      @(negedge clk);
   endtask

   task automatic wr_data(input logic [15:0] a, input logic [15:0] d, input logic byte_w);
      int         lat, stb;
      logic [1:0] sidx;
      int         i;
      lat    = 99;
      stb    = 0;
      sidx   = 2'd0;
      i      = int'(a[2:1]);
      ad_in  = d;
      wtbt_n = ~byte_w;
      dout_n = 1'b0;
      if (!byte_w)   mdl[i]       = d;
      else if (a[0]) mdl[i][15:8] = d[15:8];
      else           mdl[i][7:0]  = d[7:0];
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (wr_stb) begin stb++; sidx = wr_idx; end
         if (rply_oe) begin lat = k; break; end
      end
      check("wr_latency", 64'(lat), 64'd4);
      check("wr_stb_count", 64'(stb), 64'd1);
      check("wr_idx", 64'(sidx), 64'(a[2:1]));
      check("wr_regs", reg_q, mdl_bank());
      @(negedge clk);
      dout_n = 1'b1;
      lat    = 99;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (!rply_oe) begin lat = k; break; end
      end
      check("wr_release_lat", 64'(lat), 64'd3);
      @(negedge clk);
      wtbt_n = 1'b1;
   endtask

   task automatic nonsel(input logic [15:0] a, input logic bs, input logic use_din);
      logic seen;
      seen = 1'b0;
      addr_phase(a, bs, ~use_din);
      ad_in = 16'($urandom);
      if (use_din) din_n = 1'b0;
      else         dout_n = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rply_oe || ad_oe || wr_stb) seen = 1'b1;
      end
      check("nonsel_quiet", 64'(seen), 64'd0);
      end_cycle();
      check("nonsel_regs", reg_q, mdl_bank());
   endtask

   task automatic wait_rply(input string tag);
      int lat;
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (rply_oe) begin lat = k; break; end
      end
      check(tag, 64'(lat), 64'd4);
   endtask

   initial begin
      logic [15:0] a, d;
      int          op, lat;
      n_chk  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      ad_in  = '0;
      sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
      wtbt_n = 1'b1; bs_n = 1'b1; init_n = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      repeat (3) @(negedge clk);
      check("reset_regs", reg_q, 64'd0);
      check("reset_rply", 64'(rply_oe), 64'd0);
      check("reset_ad_oe", 64'(ad_oe), 64'd0);
      check("reset_ad_out", 64'(ad_out), 64'd0);
      check("reset_wr", 64'({wr_stb, wr_idx}), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // DATI from a preloaded register
      addr_phase(16'o177562, 1'b1, 1'b1); wr_data(16'o177562, 16'o012345, 1'b0); end_cycle();
      addr_phase(16'o177562, 1'b1, 1'b0); rd_data(16'o012345); end_cycle();
      // DATO word and DATOB both byte lanes
      addr_phase(16'o177564, 1'b1, 1'b1); wr_data(16'o177564, 16'o170017, 1'b0); end_cycle();
      addr_phase(16'o177567, 1'b1, 1'b1); wr_data(16'o177567, 16'o125000, 1'b1); end_cycle();
      check("datob_odd", 64'(reg_q[63:48]), 64'(16'o125000));
      addr_phase(16'o177566, 1'b1, 1'b1); wr_data(16'o177566, 16'o000377, 1'b1); end_cycle();
      check("datob_even", 64'(reg_q[63:48]), 64'(16'o125377));
      // Non-selected: wrong page, no BS
      nonsel(16'o177540, 1'b1, 1'b1);
      nonsel(16'o177560, 1'b0, 1'b0);
      nonsel(16'o177564, 1'b0, 1'b1);
      // DATIO returns the old value then writes
      addr_phase(16'o177564, 1'b1, 1'b1);
      rd_data(16'o170017);
      wr_data(16'o177564, 16'o054321, 1'b0);
      end_cycle();

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 4));
         a  = BASE + 16'($urandom_range(0, 7));
         d  = 16'($urandom);
         case (op)
            0: begin addr_phase(a, 1'b1, 1'b0); rd_data(mdl[a[2:1]]); end_cycle(); end
            1: begin addr_phase(a, 1'b1, 1'b1); wr_data(a, d, 1'b0); end_cycle(); end
            2: begin addr_phase(a, 1'b1, 1'b1); wr_data(a, d, 1'b1); end_cycle(); end
            3: begin
               addr_phase(a, 1'b1, 1'b1);
               rd_data(mdl[a[2:1]]);
               wr_data(a, d, 1'($urandom_range(0, 1)));
               end_cycle();
            end
            default: nonsel(16'o177000 + 16'($urandom_range(0, 16'o577)), 1'b1, 1'($urandom_range(0, 1)));
         endcase
      end
      check("random_final_regs", reg_q, mdl_bank());

      // INIT during RD_RPLY
      addr_phase(16'o177560, 1'b1, 1'b1); wr_data(16'o177560, 16'o111111, 1'b0); end_cycle();
      addr_phase(16'o177562, 1'b1, 1'b0);
      din_n = 1'b0;
      wait_rply("init_pre_rply");
      @(negedge clk);
      init_n = 1'b0;
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (!rply_oe && !ad_oe) begin lat = k; break; end
      end
      check("init_release_lat", 64'(lat), 64'd3);
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      check("init_regs", reg_q, 64'd0);
      @(negedge clk);
      init_n = 1'b1;
      end_cycle();
      repeat (3) @(negedge clk);
      addr_phase(16'o177566, 1'b1, 1'b1); wr_data(16'o177566, 16'o007070, 1'b0); end_cycle();
      addr_phase(16'o177566, 1'b1, 1'b0); rd_data(16'o007070); end_cycle();

      // Asynchronous reset while RPLY is driven
      addr_phase(16'o177566, 1'b1, 1'b0);
      din_n = 1'b0;
      wait_rply("arst_pre_rply");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_rply", 64'(rply_oe), 64'd0);
      check("arst_ad_oe", 64'(ad_oe), 64'd0);
      check("arst_regs", reg_q, 64'd0);
      sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
